// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        DM_WAIT = 2'd2
    } arb_state_e;

    localparam int MEM_LAT_DEFAULT = 2;

    function automatic int lat_cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

    localparam int         LAT_CNT_W = lat_cnt_width(MEM_LAT_DEFAULT);
    localparam logic [3:0] W_EN_LOAD = 4'b0000;

endpackage

// File: rtl/mem_port_arbiter_lat_timer.sv
// mem_lat_timer: a start pulse loads MEM_LAT, and done pulses in the cycle
// that lies exactly MEM_LAT cycles after start.
module mem_lat_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    localparam int               CNT_W    = lat_cnt_width(MEM_LAT);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT);

    logic [CNT_W-1:0] cnt_reg;

    // The counter reads MEM_LAT one cycle after start, so a value of 1 marks
    // the cycle that lies MEM_LAT cycles after the issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (start) begin
            cnt_reg <= LOAD_VAL;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign done = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between fetch (IF) and load/store (MEM).
// Optional MEM_ARB_PERF_EN adds saturating stall-cycle performance counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [3:0]        dm_w_en,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              fetch_stall,
    output logic              mem_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_w_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_stall_cnt,
    output logic [31:0]       perf_dm_stall_cnt
`endif
);

    arb_state_e state_reg;
    logic       discard_reg;
    logic       in_idle;
    logic       issue_dm;
    logic       issue_if;
    logic       lat_done;

    // Every output is qualified by rst_n so nothing leaks out while reset is held.
    assign in_idle  = rst_n && (state_reg == IDLE);
    assign issue_dm = in_idle && dm_req;
    assign issue_if = in_idle && !dm_req && if_req && !if_flush;

    assign mem_req   = issue_dm || issue_if;
    assign mem_addr  = issue_dm ? dm_addr : (issue_if ? if_addr : '0);
    assign mem_w_en  = issue_dm ? dm_w_en : W_EN_LOAD;
    assign mem_wdata = issue_dm ? dm_wdata : '0;

    mem_lat_timer #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mem_req),
        .done  (lat_done)
    );

    // A flush landing in the completion cycle itself must also kill the response.
    assign dm_done  = rst_n && (state_reg == DM_WAIT) && lat_done;
    assign if_valid = rst_n && (state_reg == IF_WAIT) && lat_done
                      && !discard_reg && !if_flush;
    assign dm_rdata = dm_done  ? mem_rdata : '0;
    assign if_rdata = if_valid ? mem_rdata : '0;

    assign mem_stall   = rst_n && dm_req && !dm_done;
    assign fetch_stall = mem_stall || (rst_n && if_req && !if_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            discard_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    discard_reg <= 1'b0;
                    if (issue_dm) begin
                        state_reg <= DM_WAIT;
                    end else if (issue_if) begin
                        state_reg <= IF_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (lat_done) begin
                        state_reg   <= IDLE;
                        discard_reg <= 1'b0;
                    end else if (if_flush) begin
                        discard_reg <= 1'b1;
                    end
                end
                DM_WAIT: begin
                    if (lat_done) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    discard_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [1:0]       stall_vec;
    logic [1:0][31:0] perf_cnt;

    assign stall_vec = {mem_stall, fetch_stall};

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        logic [31:0] cnt_reg;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (stall_vec[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end

        assign perf_cnt[gi] = cnt_reg;
    end

    assign perf_if_stall_cnt = perf_cnt[0];
    assign perf_dm_stall_cnt = perf_cnt[1];
`else
    // Without performance counters the arbiter carries no extra state.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run checked against a timestamp-based model of the arbitration rules.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              if_req   = 1'b0;
    logic [ADDR_W-1:0] if_addr  = '0;
    logic              if_flush = 1'b0;
    logic              dm_req   = 1'b0;
    logic [ADDR_W-1:0] dm_addr  = '0;
    logic [3:0]        dm_w_en  = '0;
    logic [DATA_W-1:0] dm_wdata = '0;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;
    logic              fetch_stall;
    logic              mem_stall;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_w_en;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]       perf_if_stall_cnt;
    logic [31:0]       perf_dm_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_flush    (if_flush),
        .if_valid    (if_valid),
        .if_rdata    (if_rdata),
        .dm_req      (dm_req),
        .dm_addr     (dm_addr),
        .dm_w_en     (dm_w_en),
        .dm_wdata    (dm_wdata),
        .dm_done     (dm_done),
        .dm_rdata    (dm_rdata),
        .fetch_stall (fetch_stall),
        .mem_stall   (mem_stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_w_en    (mem_w_en),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_stall_cnt (perf_if_stall_cnt),
        .perf_dm_stall_cnt (perf_dm_stall_cnt)
`endif
    );

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Fixed-latency memory: data for an issue appears MEM_LAT cycles later,
    // otherwise the read bus carries junk.
    logic [DATA_W-1:0] rd_pipe [MEM_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= mem_req ? mem_word(mem_addr) : DATA_W'($urandom);
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = '0; if_flush = 0;
        dm_req = 0; dm_addr = '0; dm_w_en = '0; dm_wdata = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        logic [255:0] all_out;
        clear_inputs();
        rst_n = 0;
        step();
        dm_req = 1; dm_addr = 32'h10; if_req = 1; if_addr = 32'h20;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_mem_stall got=%b exp=0", mem_stall); end
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_fetch_stall got=%b exp=0", fetch_stall); end
        step();
        clear_inputs();
        rst_n = 1;
        @(negedge clk);
        all_out = {mem_req, mem_addr, mem_w_en, mem_wdata, if_valid, if_rdata,
                   dm_done, dm_rdata, fetch_stall, mem_stall};
        checks++; if (all_out !== '0) begin errors++; $display("FAIL idle_outputs got=%h exp=0", all_out); end
`ifdef MEM_ARB_PERF_EN
        checks++; if ({perf_if_stall_cnt, perf_dm_stall_cnt} !== 64'd0) begin errors++; $display("FAIL reset_perf got=%h/%h exp=0/0", perf_if_stall_cnt, perf_dm_stall_cnt); end
`endif
        $display("txn reset: outputs idle");
    endtask

    task automatic test_single_load();
        apply_reset();
        dm_req = 1; dm_addr = 32'h100; dm_w_en = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (mem_req !== (c == 0)) begin errors++; $display("FAIL load_mem_req c=%0d got=%b exp=%b", c, mem_req, c == 0); end
            checks++; if (dm_done !== (c == 2)) begin errors++; $display("FAIL load_dm_done c=%0d got=%b exp=%b", c, dm_done, c == 2); end
            checks++; if (mem_stall !== (c < 2)) begin errors++; $display("FAIL load_mem_stall c=%0d got=%b exp=%b", c, mem_stall, c < 2); end
            if (c == 0) begin
                checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL load_mem_addr got=%h exp=00000100", mem_addr); end
            end
            if (c == 2) begin
                checks++; if (dm_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_dm_rdata got=%h exp=deadbeef", dm_rdata); end
            end
            step();
            if (c == 2) dm_req = 0;
        end
        $display("txn load addr=00000100 rdata=%h", 32'hDEAD_BEEF);
    endtask

    task automatic test_simultaneous();
        apply_reset();
        dm_req = 1; dm_addr = 32'h140; if_req = 1; if_addr = 32'h300;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (mem_req !== (c == 0 || c == 3)) begin errors++; $display("FAIL sim_mem_req c=%0d got=%b exp=%b", c, mem_req, c == 0 || c == 3); end
            checks++; if (dm_done !== (c == 2)) begin errors++; $display("FAIL sim_dm_done c=%0d got=%b exp=%b", c, dm_done, c == 2); end
            checks++; if (if_valid !== (c == 5)) begin errors++; $display("FAIL sim_if_valid c=%0d got=%b exp=%b", c, if_valid, c == 5); end
            checks++; if (fetch_stall !== (c <= 4)) begin errors++; $display("FAIL sim_fetch_stall c=%0d got=%b exp=%b", c, fetch_stall, c <= 4); end
            if (c == 0) begin
                checks++; if (mem_addr !== 32'h140) begin errors++; $display("FAIL sim_dm_addr got=%h exp=00000140", mem_addr); end
            end
            if (c == 3) begin
                checks++; if (mem_addr !== 32'h300) begin errors++; $display("FAIL sim_if_addr got=%h exp=00000300", mem_addr); end
            end
            if (c == 5) begin
                checks++; if (if_rdata !== mem_word(32'h300)) begin errors++; $display("FAIL sim_if_rdata got=%h exp=%h", if_rdata, mem_word(32'h300)); end
            end
            step();
            if (c == 2) dm_req = 0;
            if (c == 5) if_req = 0;
        end
`ifdef MEM_ARB_PERF_EN
        @(negedge clk);
        checks++; if (perf_if_stall_cnt !== 32'd5) begin errors++; $display("FAIL perf_if_cnt got=%0d exp=5", perf_if_stall_cnt); end
        checks++; if (perf_dm_stall_cnt !== 32'd2) begin errors++; $display("FAIL perf_dm_cnt got=%0d exp=2", perf_dm_stall_cnt); end
`endif
        $display("txn simultaneous: dm 00000140 done c2, if 00000300 valid c5");
    endtask

    task automatic test_fetch_flush();
        apply_reset();
        if_req = 1; if_addr = 32'h180;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (mem_req !== (c == 0 || c == 3)) begin errors++; $display("FAIL flush_mem_req c=%0d got=%b exp=%b", c, mem_req, c == 0 || c == 3); end
            checks++; if (if_valid !== (c == 5)) begin errors++; $display("FAIL flush_if_valid c=%0d got=%b exp=%b", c, if_valid, c == 5); end
            if (c == 3) begin
                checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL flush_new_pc got=%h exp=00000200", mem_addr); end
            end
            if (c == 5) begin
                checks++; if (if_rdata !== mem_word(32'h200)) begin errors++; $display("FAIL flush_if_rdata got=%h exp=%h", if_rdata, mem_word(32'h200)); end
            end
            step();
            if (c == 0) begin if_flush = 1; if_addr = 32'h200; end
            if (c == 1) if_flush = 0;
            if (c == 5) if_req = 0;
        end
        $display("txn flush: fetch 00000180 discarded, refetch 00000200");
    endtask

    task automatic test_store();
        apply_reset();
        dm_req = 1; dm_addr = 32'h40; dm_w_en = 4'b0011; dm_wdata = 32'h1234;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (mem_w_en !== ((c == 0) ? 4'b0011 : 4'b0000)) begin errors++; $display("FAIL store_w_en c=%0d got=%b", c, mem_w_en); end
            checks++; if (mem_wdata !== ((c == 0) ? 32'h1234 : 32'h0)) begin errors++; $display("FAIL store_wdata c=%0d got=%h", c, mem_wdata); end
            checks++; if (dm_done !== (c == 2)) begin errors++; $display("FAIL store_dm_done c=%0d got=%b exp=%b", c, dm_done, c == 2); end
            step();
            if (c == 2) clear_inputs();
        end
        $display("txn store addr=00000040 w_en=0011 wdata=00001234");
    endtask

    task automatic test_reset_mid_access();
        logic [255:0] all_out;
        apply_reset();
        dm_req = 1; dm_addr = 32'h100;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_issue got=%b exp=1", mem_req); end
        step();
        rst_n = 0;
        @(negedge clk);
        checks++; if (dm_done !== 1'b0) begin errors++; $display("FAIL rmid_done_c1 got=%b exp=0", dm_done); end
        step();
        rst_n = 1; dm_req = 0;
        @(negedge clk);
        all_out = {mem_req, mem_addr, mem_w_en, mem_wdata, if_valid, if_rdata,
                   dm_done, dm_rdata, fetch_stall, mem_stall};
        checks++; if (all_out !== '0) begin errors++; $display("FAIL rmid_outputs_c2 got=%h exp=0", all_out); end
        step();
        dm_req = 1; dm_addr = 32'h44;
        for (int c = 3; c < 6; c++) begin
            @(negedge clk);
            checks++; if (mem_req !== (c == 3)) begin errors++; $display("FAIL rmid_reissue c=%0d got=%b exp=%b", c, mem_req, c == 3); end
            checks++; if (dm_done !== (c == 5)) begin errors++; $display("FAIL rmid_done c=%0d got=%b exp=%b", c, dm_done, c == 5); end
            if (c == 5) begin
                checks++; if (dm_rdata !== mem_word(32'h44)) begin errors++; $display("FAIL rmid_rdata got=%h exp=%h", dm_rdata, mem_word(32'h44)); end
            end
            step();
        end
        clear_inputs();
        $display("txn reset mid-access: aborted load, reissued 00000044");
    endtask

    // Model: an access issued at cycle T answers at T+MEM_LAT; the port is free after that.
    task automatic test_random();
        int          busy_end = -1;
        bit          owner_dm = 0;
        bit          flushed  = 0;
        bit          last_done = 0;
        bit          last_valid = 0;
        bit          free_now, exp_dm, exp_if, exp_done, exp_valid, exp_mstall, exp_fstall;
        logic [31:0] issue_addr = '0;
        logic [31:0] exp_addr, exp_wdata, exp_rdata;
        logic [3:0]  exp_wen;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if_flush = 0;
            if (dm_req && last_done) begin
                dm_req = 0;
            end else if (!dm_req && $urandom_range(3) == 0) begin
                dm_req   = 1;
                dm_addr  = 32'($urandom_range(0, 1023)) << 2;
                dm_w_en  = ($urandom_range(1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
                dm_wdata = $urandom;
            end
            if (if_req && last_valid) begin
                if_addr = if_addr + 32'd4;
                if_req  = ($urandom_range(3) != 0);
            end else if (!if_req && $urandom_range(1) == 0) begin
                if_req  = 1;
                if_addr = 32'($urandom_range(0, 1023)) << 2;
            end
            if ($urandom_range(9) == 0) begin
                if_flush = 1;
                if_addr  = 32'($urandom_range(0, 1023)) << 2;
            end
            @(negedge clk);
            free_now   = (c > busy_end);
            exp_dm     = free_now && dm_req;
            exp_if     = free_now && !dm_req && if_req && !if_flush;
            exp_done   = (c == busy_end) && owner_dm;
            exp_valid  = (c == busy_end) && !owner_dm && !flushed && !if_flush;
            exp_mstall = dm_req && !exp_done;
            exp_fstall = exp_mstall || (if_req && !exp_valid);
            exp_addr   = exp_dm ? dm_addr : (exp_if ? if_addr : 32'h0);
            exp_wen    = exp_dm ? dm_w_en : 4'b0000;
            exp_wdata  = exp_dm ? dm_wdata : 32'h0;
            exp_rdata  = mem_word(issue_addr);
            checks++; if (mem_req !== (exp_dm || exp_if)) begin errors++; $display("FAIL rnd_mem_req c=%0d got=%b exp=%b", c, mem_req, exp_dm || exp_if); end
            checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL rnd_mem_addr c=%0d got=%h exp=%h", c, mem_addr, exp_addr); end
            checks++; if (mem_w_en !== exp_wen) begin errors++; $display("FAIL rnd_mem_w_en c=%0d got=%b exp=%b", c, mem_w_en, exp_wen); end
            checks++; if (mem_wdata !== exp_wdata) begin errors++; $display("FAIL rnd_mem_wdata c=%0d got=%h exp=%h", c, mem_wdata, exp_wdata); end
            checks++; if (dm_done !== exp_done) begin errors++; $display("FAIL rnd_dm_done c=%0d got=%b exp=%b", c, dm_done, exp_done); end
            checks++; if (if_valid !== exp_valid) begin errors++; $display("FAIL rnd_if_valid c=%0d got=%b exp=%b", c, if_valid, exp_valid); end
            checks++; if (dm_rdata !== (exp_done ? exp_rdata : 32'h0)) begin errors++; $display("FAIL rnd_dm_rdata c=%0d got=%h exp=%h", c, dm_rdata, exp_done ? exp_rdata : 32'h0); end
            checks++; if (if_rdata !== (exp_valid ? exp_rdata : 32'h0)) begin errors++; $display("FAIL rnd_if_rdata c=%0d got=%h exp=%h", c, if_rdata, exp_valid ? exp_rdata : 32'h0); end
            checks++; if (mem_stall !== exp_mstall) begin errors++; $display("FAIL rnd_mem_stall c=%0d got=%b exp=%b", c, mem_stall, exp_mstall); end
            checks++; if (fetch_stall !== exp_fstall) begin errors++; $display("FAIL rnd_fetch_stall c=%0d got=%b exp=%b", c, fetch_stall, exp_fstall); end
            if (exp_done)  $display("txn rnd c=%0d dm addr=%h rdata=%h", c, issue_addr, exp_rdata);
            if (exp_valid) $display("txn rnd c=%0d if addr=%h rdata=%h", c, issue_addr, exp_rdata);
            if (!owner_dm && c <= busy_end && if_flush) flushed = 1;
            if (exp_dm || exp_if) begin
                busy_end   = c + MEM_LAT;
                owner_dm   = exp_dm;
                flushed    = 0;
                issue_addr = exp_addr;
            end
            last_done  = exp_done;
            last_valid = exp_valid;
            step();
        end
        clear_inputs();
        for (int i = 0; i <= MEM_LAT; i++) step();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_simultaneous();
        test_fetch_flush();
        test_store();
        test_reset_mid_access();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
